// File: rtl/reg_trace_rules.sv
// Trace trigger match-rule register bank: indirect per-rule pattern/mask/hit-count access, shadowed edits with commit.
// Latency: writes land on the write edge, read_data is registered (one cycle), commit/resync pulses follow the write edge by one cycle.
// Backpressure: none, the register bus is never stalled; hit counters saturate. Optional feature macro: TRACE_RULES_SHADOW_EN.
module reg_trace_rules #(
    parameter int         pMATCH_RULES  = 8,
    parameter int         pBUFFER_SIZE  = 64,
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [1:0] pSELECT       = 2'b10
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic [7:0]                           reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic                                 selected,
    input  logic [pMATCH_RULES-1:0]              I_match_hit,
    input  logic                                 I_synchronized,
    input  logic                                 I_overflow,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_pattern,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_mask,
    output logic [pMATCH_RULES-1:0]              O_pattern_enable,
    output logic [pMATCH_RULES-1:0]              O_pattern_trig_enable,
    output logic                                 O_commit_pulse,
    output logic                                 O_reset_sync
);
    localparam int NB = pBUFFER_SIZE / 8;
    localparam int VW = pMATCH_RULES * pBUFFER_SIZE;
    // "RuleBank" with byte 0 ('R') in the least significant byte
    localparam logic [63:0] NAME_STR = 64'h6B6E_6142_656C_7552;

    localparam logic [5:0] A_NAME      = 6'h00;
    localparam logic [5:0] A_REV       = 6'h01;
    localparam logic [5:0] A_INDEX     = 6'h02;
    localparam logic [5:0] A_PATTERN   = 6'h03;
    localparam logic [5:0] A_MASK      = 6'h04;
    localparam logic [5:0] A_PAT_EN    = 6'h05;
    localparam logic [5:0] A_TRIG_EN   = 6'h06;
    localparam logic [5:0] A_COMMIT    = 6'h07;
    localparam logic [5:0] A_STATUS    = 6'h08;
    localparam logic [5:0] A_HIT_COUNT = 6'h09;
    localparam logic [5:0] A_CNT_CLEAR = 6'h0A;
    localparam logic [5:0] A_RST_SYNC  = 6'h0B;

    logic [5:0]              addr;
    logic                    sel_wr;
    logic                    wr_pat, wr_msk, wr_en, wr_ten, wr_commit, wr_clr;
    logic [3:0]              rule_index;
    logic [VW-1:0]           sh_pat, sh_msk;
    logic [pMATCH_RULES-1:0] sh_en, sh_ten;
    logic [VW-1:0]           lv_pat, lv_msk;
    logic [pMATCH_RULES-1:0] lv_en, lv_ten;
    logic                    pending;
    logic                    ovf_sticky;
    logic [15:0]             hit_cnt [pMATCH_RULES];
    logic [7:0]              rd_byte;

    assign addr      = reg_address[5:0];
    assign selected  = reg_addrvalid && (reg_address[7:6] == pSELECT);
    assign sel_wr    = selected && reg_write;
    assign wr_pat    = sel_wr && (addr == A_PATTERN);
    assign wr_msk    = sel_wr && (addr == A_MASK);
    assign wr_en     = sel_wr && (addr == A_PAT_EN);
    assign wr_ten    = sel_wr && (addr == A_TRIG_EN);
    assign wr_commit = sel_wr && (addr == A_COMMIT);
    assign wr_clr    = sel_wr && (addr == A_CNT_CLEAR);

    // Editable copy of the rules plus the index register; out-of-range index/lane/bit writes simply match nothing
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            rule_index <= 4'h0;
            sh_pat     <= '0;
            sh_msk     <= '1;
            sh_en      <= '0;
            sh_ten     <= '0;
        end else begin
            if (sel_wr && (addr == A_INDEX)) begin
                rule_index <= write_data[3:0];
            end
            for (int r = 0; r < pMATCH_RULES; r++) begin
                for (int b = 0; b < NB; b++) begin
                    if (rule_index == 4'(r) && reg_bytecnt == pBYTECNT_SIZE'(b)) begin
                        if (wr_pat) sh_pat[(r*NB+b)*8 +: 8] <= write_data;
                        if (wr_msk) sh_msk[(r*NB+b)*8 +: 8] <= write_data;
                    end
                end
                if (reg_bytecnt == pBYTECNT_SIZE'(r / 8)) begin
                    if (wr_en)  sh_en[r]  <= write_data[r % 8];
                    if (wr_ten) sh_ten[r] <= write_data[r % 8];
                end
            end
        end
    end

`ifdef TRACE_RULES_SHADOW_EN
    // Live rules move only on a commit so the trigger never sees a half-written rule
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            lv_pat <= '0;
            lv_msk <= '1;
            lv_en  <= '0;
            lv_ten <= '0;
        end else if (wr_commit) begin
            lv_pat <= sh_pat;
            lv_msk <= sh_msk;
            lv_en  <= sh_en;
            lv_ten <= sh_ten;
        end
    end

    // Pending flags edits not yet committed; the commit clears it
    always_ff @(posedge usb_clk) begin
        if (reset_i || wr_commit) begin
            pending <= 1'b0;
        end else if (wr_pat || wr_msk || wr_en || wr_ten) begin
            pending <= 1'b1;
        end
    end
`else
    // Without shadowing the edit copy is the live copy
    assign lv_pat  = sh_pat;
    assign lv_msk  = sh_msk;
    assign lv_en   = sh_en;
    assign lv_ten  = sh_ten;
    assign pending = 1'b0;
`endif

    assign O_pattern             = lv_pat;
    assign O_mask                = lv_msk;
    assign O_pattern_enable      = lv_en;
    assign O_pattern_trig_enable = lv_ten;

    // Saturating per-rule hit counters; a clear beats a coincident hit
    always_ff @(posedge usb_clk) begin
        for (int r = 0; r < pMATCH_RULES; r++) begin
            if (reset_i || wr_clr) begin
                hit_cnt[r] <= 16'h0000;
            end else if (I_match_hit[r] && hit_cnt[r] != 16'hFFFF) begin
                hit_cnt[r] <= hit_cnt[r] + 16'd1;
            end
        end
    end

    // Sticky overflow; a new overflow beats a coincident write-1-to-clear
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            ovf_sticky <= 1'b0;
        end else if (I_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (sel_wr && addr == A_STATUS && write_data[1]) begin
            ovf_sticky <= 1'b0;
        end
    end

    // One-cycle pulses following commit and resync writes
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            O_commit_pulse <= 1'b0;
            O_reset_sync   <= 1'b0;
        end else begin
            O_commit_pulse <= wr_commit;
            O_reset_sync   <= sel_wr && (addr == A_RST_SYNC);
        end
    end

    // Read mux: anything unmapped, write-only, out of range or beyond the lane count reads 0
    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            A_NAME: begin
                for (int b = 0; b < 8; b++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_byte = NAME_STR[b*8 +: 8];
                end
            end
            A_REV:   rd_byte = 8'h02;
            A_INDEX: rd_byte = {4'h0, rule_index};
            A_PATTERN, A_MASK: begin
                for (int r = 0; r < pMATCH_RULES; r++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (rule_index == 4'(r) && reg_bytecnt == pBYTECNT_SIZE'(b)) begin
                            rd_byte = (addr == A_PATTERN) ? sh_pat[(r*NB+b)*8 +: 8]
                                                          : sh_msk[(r*NB+b)*8 +: 8];
                        end
                    end
                end
            end
            A_PAT_EN, A_TRIG_EN: begin
                for (int r = 0; r < pMATCH_RULES; r++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(r / 8)) begin
                        rd_byte[r % 8] = (addr == A_PAT_EN) ? sh_en[r] : sh_ten[r];
                    end
                end
            end
            A_STATUS: rd_byte = {5'b00000, I_synchronized, ovf_sticky, pending};
            A_HIT_COUNT: begin
                for (int r = 0; r < pMATCH_RULES; r++) begin
                    if (rule_index == 4'(r)) begin
                        if (reg_bytecnt == pBYTECNT_SIZE'(0)) rd_byte = hit_cnt[r][7:0];
                        if (reg_bytecnt == pBYTECNT_SIZE'(1)) rd_byte = hit_cnt[r][15:8];
                    end
                end
            end
            default: rd_byte = 8'h00;
        endcase
    end

    // Registered read data, zero when no read was addressed to this block
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            read_data <= 8'h00;
        end else if (selected && reg_read) begin
            read_data <= rd_byte;
        end else begin
            read_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_reg_trace_rules.sv
`timescale 1ns/1ps
// Bench for reg_trace_rules: directed register traffic; read responses checked by a scoreboard monitor.
// Expectations follow the build: with TRACE_RULES_SHADOW_EN edits wait for a commit, otherwise they are live at once.
// Direct checks cover the live output buses and pulses.
module tb_reg_trace_rules;
    localparam int R = 8;
    localparam int W = 64;
`ifdef TRACE_RULES_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic           usb_clk = 1'b0;
    logic           reset_i = 1'b1;
    logic [7:0]     reg_address = 8'h00;
    logic [6:0]     reg_bytecnt = 7'h00;
    logic [7:0]     write_data = 8'h00;
    logic [7:0]     read_data;
    logic           reg_read = 1'b0;
    logic           reg_write = 1'b0;
    logic           reg_addrvalid = 1'b0;
    logic           selected;
    logic [R-1:0]   I_match_hit = '0;
    logic           I_synchronized = 1'b0;
    logic           I_overflow = 1'b0;
    logic [R*W-1:0] O_pattern, O_mask;
    logic [R-1:0]   O_pattern_enable, O_pattern_trig_enable;
    logic           O_commit_pulse, O_reset_sync;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;
    exp_t exp_q[$];

    reg_trace_rules dut (
        .usb_clk(usb_clk), .reset_i(reset_i), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .write_data(write_data), .read_data(read_data), .reg_read(reg_read), .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid), .selected(selected), .I_match_hit(I_match_hit),
        .I_synchronized(I_synchronized), .I_overflow(I_overflow), .O_pattern(O_pattern), .O_mask(O_mask),
        .O_pattern_enable(O_pattern_enable), .O_pattern_trig_enable(O_pattern_trig_enable),
        .O_commit_pulse(O_commit_pulse), .O_reset_sync(O_reset_sync)
    );

    always #5 usb_clk = ~usb_clk;

    // Read-response monitor: a read sampled on an edge is checked on the following falling edge
    logic rd_flag = 1'b0;
    always @(posedge usb_clk) rd_flag <= reg_addrvalid && (reg_address[7:6] == 2'b10) && reg_read;

    always @(negedge usb_clk) begin
        if (rd_flag) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: read_data=%02h with no expected entry", read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (read_data !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %02h expected %02h", e.nm, read_data, e.v);
                end
            end
        end
    end

    // Resync pulse monitor: total high cycles and rising edges
    int   rs_hi = 0;
    int   rs_rise = 0;
    logic rs_prev = 1'b0;
    always @(negedge usb_clk) begin
        if (O_reset_sync) rs_hi++;
        if (O_reset_sync && !rs_prev) rs_rise++;
        rs_prev <= O_reset_sync;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %016h expected %016h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [6:0] lane, input logic [7:0] d);
        @(negedge usb_clk);
        reg_address = {2'b10, a}; reg_bytecnt = lane; write_data = d;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [6:0] lane, input logic [7:0] e, input string nm);
        exp_t x;
        @(negedge usb_clk);
        reg_address = {2'b10, a}; reg_bytecnt = lane;
        reg_addrvalid = 1'b1; reg_read = 1'b1;
        x.nm = nm; x.v = e;
        exp_q.push_back(x);
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_read = 1'b0;
    endtask

    initial begin
        int rs_hi0, rs_rise0;
        logic [63:0] pat3;
        pat3 = 64'h8877665544332211;

        repeat (3) @(negedge usb_clk);
        reset_i = 1'b0;

        // Reset state
        chk("rst_mask_all_ones", {63'd0, &O_mask}, 64'd1);
        chk("rst_pattern_zero", {63'd0, |O_pattern}, 64'd0);
        chk("rst_enables", {48'd0, O_pattern_enable, O_pattern_trig_enable}, 64'd0);
        chk("rst_read_data", {56'd0, read_data}, 64'd0);
        chk("rst_pulses", {62'd0, O_commit_pulse, O_reset_sync}, 64'd0);
        rd(6'h00, 7'd0, 8'h52, "name_b0");
        rd(6'h00, 7'd7, 8'h6B, "name_b7");
        rd(6'h00, 7'd8, 8'h00, "name_b8_oob");
        rd(6'h01, 7'd0, 8'h02, "rev");
        rd(6'h07, 7'd0, 8'h00, "commit_wo_reads_0");
        rd(6'h20, 7'd0, 8'h00, "unmapped_reads_0");

        // Rule 3 pattern edit then commit
        wr(6'h02, 7'd0, 8'h03);
        rd(6'h02, 7'd0, 8'h03, "rule_index");
        for (int i = 0; i < 8; i++) wr(6'h03, 7'(i), 8'(8'h11 * (i + 1)));
        wr(6'h03, 7'd8, 8'hAA);
        chk("pat3_before_commit", O_pattern[3*W +: W], SH ? 64'd0 : pat3);
        rd(6'h08, 7'd0, SH ? 8'h01 : 8'h00, "status_pending_set");
        rd(6'h03, 7'd2, 8'h33, "pat_read_b2");
        rd(6'h03, 7'd8, 8'h00, "pat_read_b8_oob");
        wr(6'h07, 7'd0, 8'h00);
        chk("pat3_after_commit", O_pattern[3*W +: W], pat3);
        chk("commit_pulse_hi", {63'd0, O_commit_pulse}, 64'd1);
        @(negedge usb_clk);
        chk("commit_pulse_lo", {63'd0, O_commit_pulse}, 64'd0);
        rd(6'h08, 7'd0, 8'h00, "status_pending_clr");

        // Out-of-range index leaves every mask untouched
        wr(6'h02, 7'd0, 8'd8);
        wr(6'h04, 7'd0, 8'h00);
        wr(6'h07, 7'd0, 8'h00);
        chk("mask_oob_index", {63'd0, &O_mask}, 64'd1);
        rd(6'h04, 7'd0, 8'h00, "mask_oob_read");

        // Enable vectors, including an out-of-range lane
        wr(6'h05, 7'd0, 8'hA5);
        wr(6'h05, 7'd1, 8'hFF);
        wr(6'h06, 7'd0, 8'h3C);
        wr(6'h07, 7'd0, 8'h00);
        chk("pattern_enable", {56'd0, O_pattern_enable}, 64'hA5);
        chk("trig_enable", {56'd0, O_pattern_trig_enable}, 64'h3C);
        rd(6'h05, 7'd1, 8'h00, "pat_en_b1_oob");
        rd(6'h06, 7'd0, 8'h3C, "trig_en_read");

        // Hit counter saturation
        wr(6'h02, 7'd0, 8'd2);
        @(negedge usb_clk);
        I_match_hit[2] = 1'b1;
        repeat (70000) @(negedge usb_clk);
        I_match_hit[2] = 1'b0;
        rd(6'h09, 7'd0, 8'hFF, "hit_sat_lo");
        rd(6'h09, 7'd1, 8'hFF, "hit_sat_hi");
        wr(6'h02, 7'd0, 8'd1);
        rd(6'h09, 7'd0, 8'h00, "hit_rule1_zero");
        wr(6'h02, 7'd0, 8'd2);

        // Clear beats coincident hit
        @(negedge usb_clk);
        reg_address = {2'b10, 6'h0A}; reg_bytecnt = 7'd0; write_data = 8'h00;
        reg_addrvalid = 1'b1; reg_write = 1'b1; I_match_hit[2] = 1'b1;
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_write = 1'b0; I_match_hit[2] = 1'b0;
        rd(6'h09, 7'd0, 8'h00, "clear_wins_lo");
        rd(6'h09, 7'd1, 8'h00, "clear_wins_hi");
        @(negedge usb_clk);
        I_match_hit[2] = 1'b1;
        repeat (3) @(negedge usb_clk);
        I_match_hit[2] = 1'b0;
        rd(6'h09, 7'd0, 8'h03, "hit_count_3");

        // Sticky overflow: set beats coincident clear, later clear works
        I_synchronized = 1'b1;
        @(negedge usb_clk);
        reg_address = {2'b10, 6'h08}; reg_bytecnt = 7'd0; write_data = 8'h02;
        reg_addrvalid = 1'b1; reg_write = 1'b1; I_overflow = 1'b1;
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_write = 1'b0; I_overflow = 1'b0;
        rd(6'h08, 7'd0, 8'h06, "ovf_set_wins");
        wr(6'h08, 7'd0, 8'h02);
        rd(6'h08, 7'd0, 8'h04, "ovf_cleared");

        // Two resync writes, two single-cycle pulses
        rs_hi0 = rs_hi; rs_rise0 = rs_rise;
        wr(6'h0B, 7'd0, 8'h00);
        wr(6'h0B, 7'd0, 8'h00);
        repeat (3) @(negedge usb_clk);
        chk("resync_high_cycles", 64'(rs_hi - rs_hi0), 64'd2);
        chk("resync_pulses", 64'(rs_rise - rs_rise0), 64'd2);

        // Reset between edit and commit restores reset values
        wr(6'h02, 7'd0, 8'd1);
        wr(6'h03, 7'd0, 8'h5A);
        wr(6'h04, 7'd0, 8'h00);
        @(negedge usb_clk);
        reset_i = 1'b1;
        @(negedge usb_clk);
        reset_i = 1'b0;
        chk("rst2_pattern_zero", {63'd0, |O_pattern}, 64'd0);
        chk("rst2_mask_ones", {63'd0, &O_mask}, 64'd1);
        chk("rst2_enables", {48'd0, O_pattern_enable, O_pattern_trig_enable}, 64'd0);
        rd(6'h08, 7'd0, 8'h04, "rst2_status");
        rd(6'h02, 7'd0, 8'h00, "rst2_index");
        wr(6'h02, 7'd0, 8'd1);
        rd(6'h03, 7'd0, 8'h00, "rst2_shadow_pat");
        rd(6'h04, 7'd0, 8'hFF, "rst2_shadow_mask");
        wr(6'h07, 7'd0, 8'h00);
        chk("idle_commit_pulse", {63'd0, O_commit_pulse}, 64'd1);
        chk("rst2_pat1_after_commit", O_pattern[1*W +: W], 64'd0);
        wr(6'h02, 7'd0, 8'd2);
        rd(6'h09, 7'd0, 8'h00, "rst2_counter");

        repeat (3) @(negedge usb_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_missing: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
